// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / loader) arbiter for the single-port program/data RAM.
// Sequences one RAM access per IDLE -> ACCESS -> RESP pass and answers out-of-range addresses locally.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 3072,
    parameter int LD_PRIO   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    input  logic              ld_lock,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_ld;
    logic               r_gnt_ld;
    logic               r_in_range;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_ld_rdata;

    logic               w_gnt_cpu;
    logic               w_gnt_ld;
    logic               w_grant;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_in_range;
    logic [DATA_W-1:0]  w_resp_data;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < 32'(MEM_DEPTH));
    endfunction

    // Grant decision, only evaluated in IDLE so a req still high during RESP is ignored
    always_comb begin
        w_gnt_cpu = 1'b0;
        w_gnt_ld  = 1'b0;
        if (r_state == S_IDLE) begin
            if (LD_PRIO != 0) begin
                if (ld_req)
                    w_gnt_ld = 1'b1;
                else if (cpu_req && !ld_lock)
                    w_gnt_cpu = 1'b1;
            end else if (cpu_req && ld_req) begin
                w_gnt_cpu = r_last_ld;
                w_gnt_ld  = ~r_last_ld;
            end else begin
                w_gnt_cpu = cpu_req;
                w_gnt_ld  = ld_req;
            end
        end
    end

    assign w_grant        = w_gnt_cpu | w_gnt_ld;
    assign w_sel_we       = w_gnt_ld ? ld_we    : cpu_we;
    assign w_sel_addr     = w_gnt_ld ? ld_addr  : cpu_addr;
    assign w_sel_wdata    = w_gnt_ld ? ld_wdata : cpu_wdata;
    assign w_sel_in_range = addr_in_range(w_sel_addr);

    // Control state: FSM, round-robin pointer, grant owner, range flag, held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_ld   <= 1'b1;
            r_gnt_ld    <= 1'b0;
            r_in_range  <= 1'b0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt_ld   <= w_gnt_ld;
                r_last_ld  <= w_gnt_ld;
                r_in_range <= w_sel_in_range;
            end
            if (r_state == S_RESP) begin
                if (r_gnt_ld)
                    r_ld_rdata  <= w_resp_data;
                else
                    r_cpu_rdata <= w_resp_data;
            end
        end
    end

    // Captured request payload; only observed through outputs gated by state
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    always_comb begin
        if (r_we)
            w_resp_data = '0;
        else if (!r_in_range)
            w_resp_data = {DATA_W{1'b1}};
        else
            w_resp_data = ram_rdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        cpu_ack     = 1'b0;
        ld_ack      = 1'b0;
        addr_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant)
                    w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                ram_en      = r_in_range;
                ram_we      = r_in_range & r_we;
                ram_addr    = r_in_range ? r_addr  : '0;
                ram_wdata   = r_in_range ? r_wdata : '0;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                cpu_ack     = ~r_gnt_ld;
                ld_ack      = r_gnt_ld;
                addr_err    = ~r_in_range;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cpu_rdata = cpu_ack ? w_resp_data : r_cpu_rdata;
    assign ld_rdata  = ld_ack  ? w_resp_data : r_ld_rdata;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
